// File: rtl/sprite_obj_if.sv
// Sprite-ROM read port: the sprite drives enable/address, the ROM returns {gray,alpha}
// one cycle after the enable.
interface sprite_obj_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned GRAY_W = 4
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [GRAY_W:0]   bram_data;

  modport master (
    output bram_en,
    output bram_addr,
    input  bram_data
  );

  modport slave (
    input  bram_en,
    input  bram_addr,
    output bram_data
  );
endinterface

// File: rtl/sprite_obj.sv
// Movable, screen-clamped sprite with tear-free display copy and sprite-ROM addressing.
// Optional hit blinking is compiled in with `define SPRITE_BLINK_EN.
module sprite_obj #(
  parameter int unsigned H_LEN        = 10,
  parameter int unsigned V_LEN        = 10,
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned V_DISP       = 480,
  parameter int unsigned X_SIZE       = 64,
  parameter int unsigned Y_SIZE       = 64,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned GRAY_W       = 4,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned MARGIN       = 2,
  parameter int unsigned X_INIT       = 288,
  parameter int unsigned Y_INIT       = 400,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input  logic                  clk_vga,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  v_sync_i,
  input  logic [H_LEN-1:0]      req_x_addr_i,
  input  logic [V_LEN-1:0]      req_y_addr_i,
  input  logic                  move_en_i,
  input  logic [3:0]            dir_i,
  input  logic                  hit_i,
  sprite_obj_if.master          rom_io,
  output logic [3*GRAY_W-1:0]   vga_rgb_o,
  output logic                  vga_alpha_o,
  output logic [H_LEN-1:0]      x_pos_o,
  output logic [V_LEN-1:0]      y_pos_o,
  output logic                  moving_o,
  output logic                  blinking_o
);

  localparam int unsigned XW = H_LEN + 1;
  localparam int unsigned YW = V_LEN + 1;

  localparam logic [XW-1:0] XMin  = XW'(MARGIN);
  localparam logic [XW-1:0] XMax  = XW'(H_DISP - X_SIZE - MARGIN);
  localparam logic [XW-1:0] XStep = XW'(SPEED);
  localparam logic [XW-1:0] XSz   = XW'(X_SIZE);
  localparam logic [YW-1:0] YMin  = YW'(MARGIN);
  localparam logic [YW-1:0] YMax  = YW'(V_DISP - Y_SIZE - MARGIN);
  localparam logic [YW-1:0] YStep = YW'(SPEED);
  localparam logic [YW-1:0] YSz   = YW'(Y_SIZE);

  logic [H_LEN-1:0] x_pos_q, x_pos_d, x_disp_q;
  logic [V_LEN-1:0] y_pos_q, y_pos_d, y_disp_q;
  logic             moving_q, moving_d;
  logic             v_sync_q;
  logic             v_sync_rise;
  logic             in_area, in_area_q;
  logic             visible;
  logic             blinking;

  logic [XW-1:0] x_ext;
  logic [YW-1:0] y_ext;

  // Movement: each axis clamped independently; opposing directions cancel.
  always_comb begin
    x_ext   = {1'b0, x_pos_q};
    y_ext   = {1'b0, y_pos_q};
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    if (move_en_i && en_i) begin
      case (dir_i[1:0])
        2'b10:   x_pos_d = (x_ext < XMin + XStep) ? H_LEN'(XMin) : H_LEN'(x_ext - XStep);
        2'b01:   x_pos_d = (x_ext + XStep > XMax) ? H_LEN'(XMax) : H_LEN'(x_ext + XStep);
        default: x_pos_d = x_pos_q;
      endcase
      case (dir_i[3:2])
        2'b10:   y_pos_d = (y_ext < YMin + YStep) ? V_LEN'(YMin) : V_LEN'(y_ext - YStep);
        2'b01:   y_pos_d = (y_ext + YStep > YMax) ? V_LEN'(YMax) : V_LEN'(y_ext + YStep);
        default: y_pos_d = y_pos_q;
      endcase
    end
    moving_d = move_en_i && en_i && ((x_pos_d != x_pos_q) || (y_pos_d != y_pos_q));
  end

  assign v_sync_rise = v_sync_i & ~v_sync_q;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_q  <= H_LEN'(X_INIT);
      y_pos_q  <= V_LEN'(Y_INIT);
      x_disp_q <= H_LEN'(X_INIT);
      y_disp_q <= V_LEN'(Y_INIT);
      moving_q <= 1'b0;
      v_sync_q <= 1'b0;
    end else begin
      x_pos_q  <= x_pos_d;
      y_pos_q  <= y_pos_d;
      moving_q <= moving_d;
      v_sync_q <= v_sync_i;
      // Display copy only changes at frame start so a sprite never tears mid-frame.
      if (v_sync_rise) begin
        x_disp_q <= x_pos_q;
        y_disp_q <= y_pos_q;
      end
    end
  end

`ifdef SPRITE_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (hit_i) begin
      blink_cnt_d = 8'(BLINK_FRAMES);
    end else if (v_sync_rise && (blink_cnt_q != 8'd0)) begin
      blink_cnt_d = blink_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= 8'd0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blinking = (blink_cnt_q != 8'd0);
  // Counter bit 2 toggles every 4 frames: 4 shown, 4 hidden.
  assign visible  = !(blinking && blink_cnt_q[2]);
`else
  logic [8:0] unused_blink;

  assign unused_blink = {hit_i, 8'(BLINK_FRAMES)};
  assign blinking     = 1'b0;
  assign visible      = 1'b1;
`endif

  logic [XW-1:0]    req_x_ext, x_disp_ext;
  logic [YW-1:0]    req_y_ext, y_disp_ext;
  logic             in_x, in_y;
  logic [H_LEN-1:0] dx;
  logic [V_LEN-1:0] dy;

  always_comb begin
    req_x_ext  = {1'b0, req_x_addr_i};
    req_y_ext  = {1'b0, req_y_addr_i};
    x_disp_ext = {1'b0, x_disp_q};
    y_disp_ext = {1'b0, y_disp_q};
    in_x       = (req_x_ext >= x_disp_ext) && (req_x_ext < x_disp_ext + XSz);
    in_y       = (req_y_ext >= y_disp_ext) && (req_y_ext < y_disp_ext + YSz);
    // Gated by rst_n so the ROM is never enabled while the block is held in reset.
    in_area    = rst_n && en_i && visible && in_x && in_y;
    dx         = req_x_addr_i - x_disp_q;
    dy         = req_y_addr_i - y_disp_q;
  end

  assign rom_io.bram_en   = in_area;
  assign rom_io.bram_addr = in_area ? ADDR_W'(ADDR_W'(dy) * ADDR_W'(X_SIZE) + ADDR_W'(dx))
                                    : '0;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      in_area_q <= 1'b0;
    end else begin
      in_area_q <= in_area;
    end
  end

  // ROM data arrives one cycle after the enable, aligned with in_area_q.
  assign vga_rgb_o   = in_area_q ? {3{rom_io.bram_data[GRAY_W:1]}} : '0;
  assign vga_alpha_o = in_area_q ? rom_io.bram_data[0] : 1'b1;

  assign x_pos_o    = x_pos_q;
  assign y_pos_o    = y_pos_q;
  assign moving_o   = moving_q;
  assign blinking_o = blinking;

endmodule

// File: tb/tb_sprite_obj.sv
// Scoreboard bench for sprite_obj: stimulus queues expected values per cycle, a negedge
// monitor pops and compares them against the live outputs.
module tb_sprite_obj;

  logic       clk_vga = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en_i    = 1'b1;
  logic       v_sync_i = 1'b1;
  logic       move_en_i = 1'b0;
  logic       hit_i   = 1'b0;
  logic [3:0] dir_i   = 4'd0;
  logic [9:0] req_x   = 10'd1023;
  logic [9:0] req_y   = 10'd1023;

  logic [11:0] vga_rgb;
  logic        vga_alpha;
  logic [9:0]  x_pos, y_pos;
  logic        moving, blinking;

  sprite_obj_if #(.ADDR_W(12), .GRAY_W(4)) rom_if ();

  sprite_obj dut (
    .clk_vga      (clk_vga),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .v_sync_i     (v_sync_i),
    .req_x_addr_i (req_x),
    .req_y_addr_i (req_y),
    .move_en_i    (move_en_i),
    .dir_i        (dir_i),
    .hit_i        (hit_i),
    .rom_io       (rom_if),
    .vga_rgb_o    (vga_rgb),
    .vga_alpha_o  (vga_alpha),
    .x_pos_o      (x_pos),
    .y_pos_o      (y_pos),
    .moving_o     (moving),
    .blinking_o   (blinking)
  );

  always #5 clk_vga = ~clk_vga;

  int cyc = 0;
  always @(posedge clk_vga) cyc <= cyc + 1;

  typedef enum int {SX, SY, SMOV, SEN, SADDR, SRGB, SALPHA, SBLINK} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SX:      return 32'(x_pos);
      SY:      return 32'(y_pos);
      SMOV:    return 32'(moving);
      SEN:     return 32'(rom_if.bram_en);
      SADDR:   return 32'(rom_if.bram_addr);
      SRGB:    return 32'(vga_rgb);
      SALPHA:  return 32'(vga_alpha);
      default: return 32'(blinking);
    endcase
  endfunction

  always @(negedge clk_vga) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = observe(mon_e.sig);
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d, checked at %0d): got %0h, expected %0h",
                 mon_e.name, mon_e.cyc, cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic expect_at(input int dc, input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic vs_pulse();
    v_sync_i = 1'b0;
    step();
    v_sync_i = 1'b1;
    step();
  endtask

  task automatic tick(input logic [3:0] d);
    dir_i     = d;
    move_en_i = 1'b1;
    step();
    move_en_i = 1'b0;
  endtask

  task automatic tick_chk(input logic [3:0] d, input int ex, input int ey, input int mov,
                          input string n);
    expect_at(1, SX, 32'(ex), {n, "_x"});
    expect_at(1, SY, 32'(ey), {n, "_y"});
    expect_at(1, SMOV, 32'(mov), {n, "_moving"});
    tick(d);
  endtask

  task automatic set_req(input int x, input int y);
    req_x = 10'(x);
    req_y = 10'(y);
  endtask

  initial begin
    int ex;
    int cnt;
    rom_if.bram_data = 5'b10110;

    // Power-on reset
    repeat (3) step();
    expect_at(0, SX, 288, "rst_x");
    expect_at(0, SY, 400, "rst_y");
    expect_at(0, SALPHA, 1, "rst_alpha");
    expect_at(0, SEN, 0, "rst_en");
    step();
    rst_n = 1'b1;
    step();

    // ROM address, colour and right-edge exclusion at the reset position
    set_req(291, 401);
    expect_at(0, SEN, 1, "t5_en");
    expect_at(0, SADDR, 67, "t5_addr");
    step();
    expect_at(0, SRGB, 32'h0BBB, "t5_rgb");
    expect_at(0, SALPHA, 0, "t5_alpha");
    set_req(352, 400);
    expect_at(0, SEN, 0, "t5_edge_en");
    step();
    expect_at(0, SALPHA, 1, "t5_edge_alpha");
    expect_at(0, SRGB, 0, "t5_edge_rgb");
    set_req(351, 463);
    expect_at(0, SEN, 1, "corner_en");
    expect_at(0, SADDR, 4095, "corner_addr");
    step();

    // Reset asserted mid-frame after moving and while a pixel is being fetched
    tick_chk(4'b0001, 290, 400, 1, "t1_r1");
    tick(4'b0001);
    tick(4'b0001);
    vs_pulse();
    set_req(294, 400);
    expect_at(0, SEN, 1, "t1_pre_en");
    expect_at(0, SADDR, 0, "t1_pre_addr");
    step();
    v_sync_i = 1'b0;
    rst_n    = 1'b0;
    expect_at(0, SX, 288, "t1_x");
    expect_at(0, SY, 400, "t1_y");
    expect_at(0, SEN, 0, "t1_en");
    expect_at(0, SRGB, 0, "t1_rgb");
    expect_at(0, SALPHA, 1, "t1_alpha");
    expect_at(0, SMOV, 0, "t1_moving");
    step();
    rst_n    = 1'b1;
    v_sync_i = 1'b1;
    set_req(1023, 1023);
    step();

    // Left clamp from x=8
    repeat (140) tick(4'b0010);
    expect_at(0, SX, 8, "t2_start_x");
    for (int i = 0; i < 10; i++) begin
      ex = 8 - 2 * (i + 1);
      if (ex < 2) ex = 2;
      tick_chk(4'b0010, ex, 400, (i < 3) ? 1 : 0, $sformatf("t2_tick%0d", i));
    end
    tick_chk(4'b0001, 4, 400, 1, "t2_back");
    expect_at(1, SMOV, 0, "t2_idle_moving");
    step();

    // Opposing directions and diagonal from (100,100)
    repeat (48) tick(4'b1001);
    repeat (102) tick(4'b1000);
    expect_at(0, SX, 100, "t3_start_x");
    expect_at(0, SY, 100, "t3_start_y");
    tick_chk(4'b1100, 100, 100, 0, "t3_updown");
    tick_chk(4'b1010, 98, 98, 1, "t3_upleft");
    tick_chk(4'b1111, 98, 98, 0, "t3_all");

    // Right and bottom clamps
    repeat (240) tick(4'b0101);
    tick_chk(4'b0101, 574, 414, 0, "clamp_dr");

    // Disabled sprite: no motion, no ROM reads, transparent
    en_i = 1'b0;
    tick_chk(4'b0010, 574, 414, 0, "en0_move");
    set_req(288, 400);
    expect_at(0, SEN, 0, "en0_bram_en");
    step();
    expect_at(0, SALPHA, 1, "en0_alpha");
    en_i = 1'b1;
    expect_at(0, SEN, 1, "en1_bram_en");
    expect_at(0, SADDR, 0, "en1_addr");
    step();

    // Mid-frame move keeps the display copy until the next frame start
    expect_at(1, SEN, 1, "t4_old_en");
    expect_at(1, SADDR, 0, "t4_old_addr");
    tick_chk(4'b0010, 572, 414, 1, "t4_move");
    vs_pulse();
    expect_at(0, SEN, 0, "t4_stale_en");
    step();
    set_req(575, 415);
    expect_at(0, SEN, 1, "t4_new_en");
    expect_at(0, SADDR, 67, "t4_new_addr");
    step();

    // Hit response
    set_req(572, 414);
`ifdef SPRITE_BLINK_EN
    hit_i = 1'b1;
    step();
    hit_i = 1'b0;
    for (int k = 0; k <= 61; k++) begin
      cnt = (k <= 60) ? 60 - k : 0;
      expect_at(0, SBLINK, (cnt != 0) ? 1 : 0, $sformatf("t6_blink_f%0d", k));
      expect_at(0, SEN, (cnt != 0 && cnt[2]) ? 0 : 1, $sformatf("t6_visible_f%0d", k));
      vs_pulse();
    end
    v_sync_i = 1'b0;
    step();
    v_sync_i = 1'b1;
    hit_i    = 1'b1;
    step();
    hit_i = 1'b0;
    expect_at(0, SBLINK, 1, "t6_loadwins_blink");
    expect_at(0, SEN, 0, "t6_loadwins_hidden");
    step();
`else
    hit_i = 1'b1;
    step();
    hit_i = 1'b0;
    expect_at(0, SBLINK, 0, "t6_noblink");
    expect_at(0, SEN, 1, "t6_noblink_en");
    vs_pulse();
    expect_at(0, SBLINK, 0, "t6_noblink_frame");
    expect_at(0, SEN, 1, "t6_noblink_frame_en");
    step();
`endif

    for (int i = 0; i < 5 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
